dmem_ctrl: RTL and testbench

- Responder end of the core's data-memory interface (rmem/wmem, mem_addr, mem_wdata, mem_type, mem_sign, mem_rdata, busy).
- Accepts one load or store at a time and stalls the core through busy.
- Drives a word-wide synchronous SRAM port with byte enables and a configurable read latency.
- Returns lane-aligned, sign- or zero-extended load data.

---
 rtl/dmem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder between the core load/store port
// and a word-wide synchronous SRAM with byte enables.
module dmem_ctrl #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rmem,
    input  logic              wmem,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [1:0]        mem_type,
    input  logic              mem_sign,
    output logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              mem_err,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W+1:0] lat_addr;
    logic [1:0]        lat_type;
    logic              lat_sign;
    logic              lat_store;
    logic [31:0]       lat_wdata;

    logic              req;
    logic              illegal;
    logic [3:0]        be_mask;
    logic [31:0]       st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic              unused_addr_hi;

    // Address bits above the SRAM range wrap and are deliberately dropped.
    assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];

    assign req = rmem | wmem;

    // Classify the incoming request: conflicting direction, reserved size, misalignment.
    always_comb begin
        illegal = 1'b0;
        if (rmem && wmem)
            illegal = 1'b1;
        case (mem_type)
            2'b01:   if (mem_addr[0]) illegal = 1'b1;
            2'b10:   if (mem_addr[1:0] != 2'b00) illegal = 1'b1;
            2'b11:   illegal = 1'b1;
            default: ;
        endcase
    end

    // Byte enables and lane replication for the latched store.
    always_comb begin
        be_mask = 4'b0000;
        st_data = lat_wdata;
        case (lat_type)
            2'b00: begin
                be_mask = 4'b0001 << lat_addr[1:0];
                st_data = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be_mask = lat_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{lat_wdata[15:0]}};
            end
            2'b10: begin
                be_mask = 4'b1111;
                st_data = lat_wdata;
            end
            default: begin
                be_mask = 4'b0000;
                st_data = lat_wdata;
            end
        endcase
    end

    // Pick the addressed lane from the SRAM word and extend it.
    always_comb begin
        ld_byte = sram_rdata[7:0];
        case (lat_addr[1:0])
            2'b00:   ld_byte = sram_rdata[7:0];
            2'b01:   ld_byte = sram_rdata[15:8];
            2'b10:   ld_byte = sram_rdata[23:16];
            default: ld_byte = sram_rdata[31:24];
        endcase
        ld_half = lat_addr[1] ? sram_rdata[31:16] : sram_rdata[15:0];
        case (lat_type)
            2'b00:   ld_data = {{24{lat_sign & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{lat_sign & ld_half[15]}}, ld_half};
            default: ld_data = sram_rdata;
        endcase
    end

    // Stall the core from the moment a request appears until DONE/ERR.
    always_comb begin
        busy = 1'b0;
        case (state)
            S_IDLE:  busy = req;
            S_REQ:   busy = 1'b1;
            S_WAIT:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // SRAM strobes come straight from state; reset blocks any write in REQ.
    always_comb begin
        sram_en = rstn && (state == S_REQ);
        sram_we = (sram_en && lat_store) ? be_mask : 4'b0000;
    end

    assign sram_addr  = lat_addr[ADDR_W+1:2];
    assign sram_wdata = st_data;

    // Request sequencer: latch, access SRAM, wait out read latency, release core.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            lat_addr  <= '0;
            lat_type  <= 2'b00;
            lat_sign  <= 1'b0;
            lat_store <= 1'b0;
            lat_wdata <= 32'd0;
            mem_rdata <= 32'd0;
            mem_err   <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_addr  <= mem_addr[ADDR_W+1:0];
                        lat_type  <= mem_type;
                        lat_sign  <= mem_sign;
                        lat_store <= wmem & ~rmem;
                        lat_wdata <= mem_wdata;
                        if (illegal) begin
                            state   <= S_ERR;
                            mem_err <= 1'b1;
                            if (rmem)
                                mem_rdata <= 32'd0;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (lat_store) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        mem_rdata <= ld_data;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with RD_LAT=1 and RD_LAT=3
// instances, each backed by a behavioural SRAM.
module tb_dmem_ctrl;

    typedef struct packed {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  t;
        logic        s;
        int          nb;
        logic [3:0]  we;
        logic        en;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rmem, wmem, mem_sign, sel;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_type;

    logic [31:0] rdata1, wdata1, srd1;
    logic        busy1, err1, en1;
    logic [3:0]  we1;
    logic [11:0] addr1;

    logic [31:0] rdata3, wdata3, srd3, p0, p1;
    logic        busy3, err3, en3;
    logic [3:0]  we3;
    logic [11:0] addr3;

    logic [31:0] mem1 [0:4095];
    logic [31:0] mem3 [0:4095];
    int          wr_cnt1 = 0;
    int          checks = 0;
    int          errors = 0;

    logic        busy_m, err_m, en_m;
    logic [3:0]  we_m;
    logic [31:0] rdata_m;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(12), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .rmem(rmem & ~sel), .wmem(wmem & ~sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_sign(mem_sign),
        .mem_rdata(rdata1), .busy(busy1), .mem_err(err1),
        .sram_en(en1), .sram_we(we1), .sram_addr(addr1),
        .sram_wdata(wdata1), .sram_rdata(srd1)
    );

    dmem_ctrl #(.ADDR_W(12), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .rmem(rmem & sel), .wmem(wmem & sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_sign(mem_sign),
        .mem_rdata(rdata3), .busy(busy3), .mem_err(err3),
        .sram_en(en3), .sram_we(we3), .sram_addr(addr3),
        .sram_wdata(wdata3), .sram_rdata(srd3)
    );

    assign busy_m  = sel ? busy3 : busy1;
    assign err_m   = sel ? err3 : err1;
    assign en_m    = sel ? en3 : en1;
    assign we_m    = sel ? we3 : we1;
    assign rdata_m = sel ? rdata3 : rdata1;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 32'd0;
            mem3[i] = 32'd0;
        end
    end

    // SRAM model, latency 1
    always @(posedge clk) begin
        if (en1) begin
            for (int b = 0; b < 4; b++)
                if (we1[b]) mem1[addr1][8*b +: 8] <= wdata1[8*b +: 8];
            srd1 <= mem1[addr1];
        end
        if (we1 != 4'b0000) wr_cnt1 <= wr_cnt1 + 1;
    end

    // SRAM model, latency 3
    always @(posedge clk) begin
        if (en3) begin
            for (int b = 0; b < 4; b++)
                if (we3[b]) mem3[addr3][8*b +: 8] <= wdata3[8*b +: 8];
            p0 <= mem3[addr3];
        end
        p1   <= p0;
        srd3 <= p1;
    end

    // Called at posedge+1; returns at posedge+1 after the first non-busy cycle.
    task automatic do_req(input vec_t v, output int nb, output logic err,
                          output logic en_seen, output logic [3:0] we_seen,
                          output logic [31:0] rd);
        rmem = v.r; wmem = v.w; mem_addr = v.a; mem_wdata = v.d;
        mem_type = v.t; mem_sign = v.s;
        nb = 0; en_seen = 1'b0; we_seen = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_m) begin
                en_seen = 1'b1;
                we_seen = we_m;
            end
            if (busy_m) begin
                nb++;
                @(posedge clk); #1;
            end else begin
                break;
            end
        end
        err = err_m;
        rd  = rdata_m;
        @(posedge clk); #1;
        rmem = 1'b0; wmem = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sel = 1'b0; rmem = 1'b0; wmem = 1'b0;
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_type = 2'b00; mem_sign = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err1); end
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", en1); end
        checks++; if (we1 !== 4'b0000) begin errors++; $display("FAIL rst_we got %b exp 0000", we1); end
        checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata1); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rst_busy3 got %b exp 0", busy3); end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_store_load();
        vec_t v [14];
        int nb; logic er, en; logic [3:0] we; logic [31:0] rd;
        v[0]  = '{1'b0,1'b1,32'h100,32'hDEADBEEF,2'b10,1'b0,2,4'hF,1'b1,1'b0,32'h0};
        v[1]  = '{1'b1,1'b0,32'h100,32'h0,2'b10,1'b0,3,4'h0,1'b1,1'b0,32'hDEADBEEF};
        v[2]  = '{1'b0,1'b1,32'h103,32'h12345680,2'b00,1'b0,2,4'h8,1'b1,1'b0,32'hDEADBEEF};
        v[3]  = '{1'b1,1'b0,32'h103,32'h0,2'b00,1'b1,3,4'h0,1'b1,1'b0,32'hFFFFFF80};
        v[4]  = '{1'b1,1'b0,32'h103,32'h0,2'b00,1'b0,3,4'h0,1'b1,1'b0,32'h00000080};
        v[5]  = '{1'b1,1'b0,32'h100,32'h0,2'b00,1'b1,3,4'h0,1'b1,1'b0,32'hFFFFFFEF};
        v[6]  = '{1'b0,1'b1,32'h200,32'h12345678,2'b10,1'b0,2,4'hF,1'b1,1'b0,32'hFFFFFFEF};
        v[7]  = '{1'b0,1'b1,32'h202,32'hABCD8001,2'b01,1'b0,2,4'hC,1'b1,1'b0,32'hFFFFFFEF};
        v[8]  = '{1'b1,1'b0,32'h202,32'h0,2'b01,1'b1,3,4'h0,1'b1,1'b0,32'hFFFF8001};
        v[9]  = '{1'b1,1'b0,32'h202,32'h0,2'b01,1'b0,3,4'h0,1'b1,1'b0,32'h00008001};
        v[10] = '{1'b1,1'b0,32'h200,32'h0,2'b10,1'b0,3,4'h0,1'b1,1'b0,32'h80015678};
        v[11] = '{1'b1,1'b0,32'h200,32'h0,2'b01,1'b1,3,4'h0,1'b1,1'b0,32'h00005678};
        v[12] = '{1'b0,1'b1,32'h201,32'h000000A5,2'b00,1'b0,2,4'h2,1'b1,1'b0,32'h00005678};
        v[13] = '{1'b1,1'b0,32'h4100,32'h0,2'b10,1'b1,3,4'h0,1'b1,1'b0,32'h80ADBEEF};
        sel = 1'b0;
        for (int i = 0; i < 14; i++) begin
            do_req(v[i], nb, er, en, we, rd);
            checks++; if (nb !== v[i].nb) begin errors++; $display("FAIL sl%0d busy_cycles got %0d exp %0d", i, nb, v[i].nb); end
            checks++; if (we !== v[i].we) begin errors++; $display("FAIL sl%0d sram_we got %b exp %b", i, we, v[i].we); end
            checks++; if (en !== v[i].en) begin errors++; $display("FAIL sl%0d sram_en got %b exp %b", i, en, v[i].en); end
            checks++; if (er !== v[i].err) begin errors++; $display("FAIL sl%0d mem_err got %b exp %b", i, er, v[i].err); end
            checks++; if (rd !== v[i].rd) begin errors++; $display("FAIL sl%0d mem_rdata got %h exp %h", i, rd, v[i].rd); end
        end
        checks++;
        if (mem1[12'h080] !== 32'h8001A578) begin
            errors++; $display("FAIL sram_word_200 got %h exp 8001a578", mem1[12'h080]);
        end
    endtask

    task automatic test_illegal();
        vec_t v [6];
        int nb; logic er, en; logic [3:0] we; logic [31:0] rd;
        v[0] = '{1'b0,1'b1,32'h203,32'h1111,2'b01,1'b0,1,4'h0,1'b0,1'b1,32'h80ADBEEF};
        v[1] = '{1'b1,1'b0,32'h101,32'h0,2'b10,1'b0,1,4'h0,1'b0,1'b1,32'h0};
        v[2] = '{1'b1,1'b0,32'h100,32'h0,2'b10,1'b0,3,4'h0,1'b1,1'b0,32'h80ADBEEF};
        v[3] = '{1'b1,1'b0,32'h100,32'h0,2'b11,1'b0,1,4'h0,1'b0,1'b1,32'h0};
        v[4] = '{1'b1,1'b0,32'h102,32'h0,2'b01,1'b1,3,4'h0,1'b1,1'b0,32'hFFFF80AD};
        v[5] = '{1'b1,1'b1,32'h100,32'h0,2'b10,1'b0,1,4'h0,1'b0,1'b1,32'h0};
        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_req(v[i], nb, er, en, we, rd);
            checks++; if (nb !== v[i].nb) begin errors++; $display("FAIL il%0d busy_cycles got %0d exp %0d", i, nb, v[i].nb); end
            checks++; if (en !== v[i].en) begin errors++; $display("FAIL il%0d sram_en got %b exp %b", i, en, v[i].en); end
            checks++; if (er !== v[i].err) begin errors++; $display("FAIL il%0d mem_err got %b exp %b", i, er, v[i].err); end
            checks++; if (rd !== v[i].rd) begin errors++; $display("FAIL il%0d mem_rdata got %h exp %h", i, rd, v[i].rd); end
        end
        checks++;
        if (mem1[12'h080] !== 32'h8001A578) begin
            errors++; $display("FAIL illegal_no_write got %h exp 8001a578", mem1[12'h080]);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [5];
        int nb; logic er, en; logic [3:0] we; logic [31:0] rd;
        v[0] = '{1'b0,1'b1,32'h40,32'hCAFEF00D,2'b10,1'b0,2,4'hF,1'b1,1'b0,32'h0};
        v[1] = '{1'b0,1'b1,32'h44,32'h0BADC0DE,2'b10,1'b0,2,4'hF,1'b1,1'b0,32'h0};
        v[2] = '{1'b1,1'b0,32'h40,32'h0,2'b10,1'b0,5,4'h0,1'b1,1'b0,32'hCAFEF00D};
        v[3] = '{1'b1,1'b0,32'h44,32'h0,2'b10,1'b0,5,4'h0,1'b1,1'b0,32'h0BADC0DE};
        v[4] = '{1'b1,1'b0,32'h45,32'h0,2'b00,1'b1,5,4'h0,1'b1,1'b0,32'hFFFFFFC0};
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_req(v[i], nb, er, en, we, rd);
            checks++; if (nb !== v[i].nb) begin errors++; $display("FAIL bb%0d busy_cycles got %0d exp %0d", i, nb, v[i].nb); end
            checks++; if (we !== v[i].we) begin errors++; $display("FAIL bb%0d sram_we got %b exp %b", i, we, v[i].we); end
            checks++; if (er !== v[i].err) begin errors++; $display("FAIL bb%0d mem_err got %b exp %b", i, er, v[i].err); end
            checks++; if (rd !== v[i].rd) begin errors++; $display("FAIL bb%0d mem_rdata got %h exp %h", i, rd, v[i].rd); end
        end
    endtask

    task automatic test_reset_wait();
        sel = 1'b1;
        rmem = 1'b1; wmem = 1'b0; mem_addr = 32'h40; mem_type = 2'b10; mem_sign = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0; rmem = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rw_busy got %b exp 0", busy3); end
        checks++; if (rdata3 !== 32'd0) begin errors++; $display("FAIL rw_rdata got %h exp 0", rdata3); end
        repeat (4) @(negedge clk);
        checks++; if (rdata3 !== 32'd0) begin errors++; $display("FAIL rw_rdata_late got %h exp 0", rdata3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rw_busy_late got %b exp 0", busy3); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_store();
        int w0;
        vec_t v;
        int nb; logic er, en; logic [3:0] we; logic [31:0] rd;
        sel = 1'b0;
        w0 = wr_cnt1;
        wmem = 1'b1; rmem = 1'b0; mem_addr = 32'h300; mem_wdata = 32'hFFFFFFFF;
        mem_type = 2'b10; mem_sign = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0; wmem = 1'b0;
        @(negedge clk);
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL rs_en got %b exp 0", en1); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rs_busy got %b exp 0", busy1); end
        checks++; if (wr_cnt1 !== w0) begin errors++; $display("FAIL rs_writes got %0d exp %0d", wr_cnt1, w0); end
        checks++; if (mem1[12'h0C0] !== 32'd0) begin errors++; $display("FAIL rs_word got %h exp 0", mem1[12'h0C0]); end
        checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL rs_rdata got %h exp 0", rdata1); end
        @(posedge clk); #1;
        v = '{1'b1,1'b0,32'h100,32'h0,2'b10,1'b0,3,4'h0,1'b1,1'b0,32'h80ADBEEF};
        do_req(v, nb, er, en, we, rd);
        checks++; if (nb !== 3) begin errors++; $display("FAIL rs_after_busy got %0d exp 3", nb); end
        checks++; if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL rs_after_rdata got %h exp 80adbeef", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_illegal();
        test_back_to_back();
        test_reset_wait();
        test_reset_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
